ras_ctrl: RTL and testbench
===========================

Name: ras_ctrl

Overview:
- Fetch-side client and owner of the return address stack: decodes each fetched instruction for RISC-V call/return hints, drives push/pop, and issues a registered return-target prediction.
- Emits a checkpoint with every prediction, restores speculative state on a pipeline flush, and flags return mispredictions detected at execute.
- Sits between the IF stage and the branch-resolution logic in EX.

Parameters:
- DEPTH, 32, number of stack entries (power of two).
- PTR_W, 5, log2(DEPTH).
- XLEN, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- if_valid  in  1  if_pc/if_instr valid this cycle.
- if_pc  in  XLEN  PC of the fetched instruction.
- if_instr  in  32  fetched instruction word.
- pred_valid  out  1  registered: pred_target is a usable return prediction.
- pred_target  out  XLEN  registered predicted return address.
- ckpt_ptr  out  PTR_W  registered pre-update write pointer of the instruction in the previous cycle.
- ckpt_count  out  PTR_W+1  registered pre-update occupancy.
- ckpt_top  out  XLEN  registered pre-update top entry (0 if empty).
- rec_valid  in  1  flush: restore checkpoint.
- rec_ptr  in  PTR_W  checkpointed pointer.
- rec_count  in  PTR_W+1  checkpointed occupancy.
- rec_top  in  XLEN  checkpointed top value.
- ex_valid  in  1  EX has a resolved return.
- ex_pred_target  in  XLEN  target predicted for that return.
- ex_actual_target  in  XLEN  resolved target.
- ret_mispredict  out  1  registered one-cycle pulse on mismatch.

Behaviour:
- State:
  - stack[DEPTH] of XLEN.
  - wptr (PTR_W): next free slot; top = stack[wptr-1] mod DEPTH.
  - count (0..DEPTH).
  - Stack contents are not reset; count gates every read.
- Reset: wptr=0, count=0, pred_valid=0, pred_target=0, ckpt_*=0, ret_mispredict=0. Reset overrides all other inputs in the same cycle, including mid-flush.
- Decode, only when if_valid:
  - link(r) = (r==1 or r==5).
  - JAL is opcode 1101111. Push if link(rd), otherwise no action.
  - JALR is opcode 1100111:
    - !link(rd), !link(rs1): none.
    - !link(rd), link(rs1): pop.
    - link(rd), !link(rs1): push.
    - link(rd), link(rs1), rd!=rs1: pop-then-push.
    - link(rd), link(rs1), rd==rs1: push.
  - Every other opcode: no action.
- Push:
  - stack[wptr] <= if_pc+4 (XLEN wrap); wptr+1 (mod DEPTH); count = min(count+1, DEPTH).
  - Overflow silently overwrites the oldest entry.
- Pop:
  - If count>0: pred_valid<=1, pred_target<=top, wptr-1, count-1.
  - If count==0: pred_valid<=0, pred_target<=0, state unchanged (no underflow wrap).
- Pop-then-push:
  - Prediction as for pop.
  - If count>0: stack[wptr-1] <= if_pc+4; wptr and count unchanged.
  - If count==0: behaves as a push.
- pred_valid is 0 for any instruction that is not a pop. Latency is exactly one cycle from if_valid to pred_*/ckpt_*.
- ckpt_* is captured every if_valid cycle from pre-update state. When if_valid=0, pred_valid=0 and ckpt_* holds.
- Recovery (rec_valid=1):
  - wptr<=rec_ptr, count<=rec_count.
  - If rec_count!=0: stack[rec_ptr-1]<=rec_top.
  - Takes priority over if_valid in the same cycle; the fetch update is dropped.
  - pred_valid<=0 that cycle.
- Mispredict check: ret_mispredict <= ex_valid & (ex_pred_target != ex_actual_target), registered, independent of rec_valid.
- count never exceeds DEPTH; rec_count>DEPTH is illegal, and the bench asserts it never occurs.

Decomposition:
- Shared package (riscv_pkg):
  - OPC_JAL, OPC_JALR opcode constants.
  - Link-register constants X1, X5.
  - ras_op_e enum {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH}.
  - ras_ckpt_t struct {ptr, count, top}.
- One combinational sub-module, ras_hint_dec: if_instr -> ras_op_e. The stack array, pointers and recovery stay in ras_ctrl.

Test Plan:
- Reset, then JAL x1 at pc=0x100 -> next cycle pred_valid=0, ckpt_count=0; count=1; stack[0]=0x104.
- Call at 0x100, call at 0x200, then JALR x0,0(x1) twice -> pred_target=0x204, then 0x104, each with pred_valid=1; count returns to 0.
- JALR x0,0(x1) on an empty stack -> pred_valid=0, wptr=0, count=0 unchanged.
- 33 JAL x1 pushes (pc=0x1000+4k) then 33 returns:
  - The first 32 returns predict 0x1084 down to 0x1008.
  - count saturates at 32.
  - The 33rd return gives pred_valid=0.
- Push 0x104, keep its ckpt {ptr=1, count=1, top=0x104}, then a pop plus a push of 0x304. Assert rec_valid with that ckpt together with if_valid -> the fetch is ignored; the next return predicts 0x104.
- JALR x5,0(x1) at 0x400 with top=0x104 -> pred_target=0x104; stack[wptr-1]=0x404; count unchanged.
- ex_valid with pred=0x104, actual=0x108 -> ret_mispredict=1 for exactly one cycle. With equal values -> stays 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch-side definitions for return-address-stack prediction.
// Provides opcode and link-register constants, RAS operation encoding,
// the checkpoint record, and the link-register test used by the decoder.
package riscv_pkg;

  localparam int RAS_DEPTH = 32;
  localparam int RAS_PTR_W = 5;
  localparam int RAS_XLEN  = 32;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [4:0] X1 = 5'd1;
  localparam logic [4:0] X5 = 5'd5;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POPPUSH
  } ras_op_e;

  typedef struct packed {
    logic [RAS_PTR_W-1:0] ptr;
    logic [RAS_PTR_W:0]   count;
    logic [RAS_XLEN-1:0]  top;
  } ras_ckpt_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == X1) || (r == X5);
  endfunction

endpackage

// File: rtl/ras_hint_dec.sv
// Combinational call/return hint decoder for RISC-V JAL/JALR.
// Ports: instr_i (fetched word) -> op_o (RAS operation to apply).
// Pure combinational; no state, no latency.
module ras_hint_dec
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  output ras_op_e     op_o
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       unused_bits;

  assign opcode      = instr_i[6:0];
  assign rd          = instr_i[11:7];
  assign rs1         = instr_i[19:15];
  assign unused_bits = ^{instr_i[31:20], instr_i[14:12]};

  always_comb begin
    op_o = RAS_NONE;
    case (opcode)
      OPC_JAL: begin
        if (is_link(rd)) op_o = RAS_PUSH;
      end
      OPC_JALR: begin
        case ({is_link(rd), is_link(rs1)})
          2'b01:   op_o = RAS_POP;
          2'b10:   op_o = RAS_PUSH;
          // Same link register on both sides is a plain call (e.g. jalr ra, ra).
          2'b11:   op_o = (rd == rs1) ? RAS_PUSH : RAS_POPPUSH;
          default: op_o = RAS_NONE;
        endcase
      end
      default: op_o = RAS_NONE;
    endcase
  end

endmodule

// File: rtl/ras_ctrl.sv
// Return address stack owner: decodes fetch hints, pushes/pops, predicts returns.
// Ports: clk/reset; if_* fetch in; pred_*/ckpt_* registered out (1 cycle);
// rec_* flush restore in; ex_* resolved return in; ret_mispredict out.
module ras_ctrl
  import riscv_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PTR_W = RAS_PTR_W,
  parameter int XLEN  = RAS_XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  output logic             pred_valid,
  output logic [XLEN-1:0]  pred_target,
  output logic [PTR_W-1:0] ckpt_ptr,
  output logic [PTR_W:0]   ckpt_count,
  output logic [XLEN-1:0]  ckpt_top,
  input  logic             rec_valid,
  input  logic [PTR_W-1:0] rec_ptr,
  input  logic [PTR_W:0]   rec_count,
  input  logic [XLEN-1:0]  rec_top,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic [XLEN-1:0]  ex_actual_target,
  output logic             ret_mispredict
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  // Contents are never reset; count_q gates every read.
  logic [XLEN-1:0]  stack_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, wptr_m1;
  logic [PTR_W:0]   count_q, count_d;
  logic             pred_valid_q, pred_valid_d;
  logic [XLEN-1:0]  pred_target_q, pred_target_d;
  ras_ckpt_t        ckpt_q, ckpt_d;
  logic             mispred_q, mispred_d;
  logic [XLEN-1:0]  top, link_addr;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [XLEN-1:0]  wr_dat;
  ras_op_e          op;

  ras_hint_dec u_dec (
    .instr_i (if_instr),
    .op_o    (op)
  );

  assign wptr_m1   = wptr_q - PTR_W'(1);
  assign top       = (count_q != '0) ? stack_q[wptr_m1] : '0;
  assign link_addr = if_pc + XLEN'(4);

  always_comb begin
    wptr_d        = wptr_q;
    count_d       = count_q;
    pred_valid_d  = 1'b0;
    pred_target_d = pred_target_q;
    ckpt_d        = ckpt_q;
    wr_en         = 1'b0;
    wr_idx        = wptr_q;
    wr_dat        = link_addr;
    mispred_d     = ex_valid && (ex_pred_target != ex_actual_target);

    if (rec_valid) begin
      // Flush wins; the concurrent fetch (and its checkpoint) is discarded.
      wptr_d  = rec_ptr;
      count_d = rec_count;
      if (rec_count != '0) begin
        wr_en  = 1'b1;
        wr_idx = rec_ptr - PTR_W'(1);
        wr_dat = rec_top;
      end
    end else if (if_valid) begin
      ckpt_d = '{ptr: wptr_q, count: count_q, top: top};
      if (op == RAS_POP || op == RAS_POPPUSH) begin
        pred_valid_d  = (count_q != '0);
        pred_target_d = top;
      end
      case (op)
        RAS_PUSH: begin
          wr_en   = 1'b1;
          wptr_d  = wptr_q + PTR_W'(1);
          count_d = (count_q == FULL) ? FULL : count_q + (PTR_W+1)'(1);
        end
        RAS_POP: begin
          // Empty stack: no underflow wrap, state untouched.
          if (count_q != '0) begin
            wptr_d  = wptr_m1;
            count_d = count_q - (PTR_W+1)'(1);
          end
        end
        RAS_POPPUSH: begin
          // Non-empty: replace top in place. Empty: degenerates to a push.
          wr_en = 1'b1;
          if (count_q != '0) begin
            wr_idx = wptr_m1;
          end else begin
            wptr_d  = wptr_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q        <= '0;
      count_q       <= '0;
      pred_valid_q  <= 1'b0;
      pred_target_q <= '0;
      ckpt_q        <= '0;
      mispred_q     <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      count_q       <= count_d;
      pred_valid_q  <= pred_valid_d;
      pred_target_q <= pred_target_d;
      ckpt_q        <= ckpt_d;
      mispred_q     <= mispred_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) stack_q[wr_idx] <= wr_dat;
  end

  assign pred_valid     = pred_valid_q;
  assign pred_target    = pred_target_q;
  assign ckpt_ptr       = ckpt_q.ptr;
  assign ckpt_count     = ckpt_q.count;
  assign ckpt_top       = ckpt_q.top;
  assign ret_mispredict = mispred_q;

endmodule

// File: tb/tb_ras_ctrl.sv
module tb_ras_ctrl;

  localparam logic [31:0] I_CALL = 32'h0000_00EF; // jal  x1, 0
  localparam logic [31:0] I_RET  = 32'h0000_8067; // jalr x0, 0(x1)
  localparam logic [31:0] I_PP   = 32'h0000_82E7; // jalr x5, 0(x1)
  localparam logic [31:0] I_NOP  = 32'h0000_0013; // addi x0, x0, 0

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic [4:0]  ckpt_ptr;
  logic [5:0]  ckpt_count;
  logic [31:0] ckpt_top;
  logic        rec_valid;
  logic [4:0]  rec_ptr;
  logic [5:0]  rec_count;
  logic [31:0] rec_top;
  logic        ex_valid;
  logic [31:0] ex_pred_target;
  logic [31:0] ex_actual_target;
  logic        ret_mispredict;

  int n_assert = 0;
  int n_fail   = 0;

  logic [4:0]  sv_ptr;
  logic [5:0]  sv_count;
  logic [31:0] sv_top;

  ras_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instr         (if_instr),
    .pred_valid       (pred_valid),
    .pred_target      (pred_target),
    .ckpt_ptr         (ckpt_ptr),
    .ckpt_count       (ckpt_count),
    .ckpt_top         (ckpt_top),
    .rec_valid        (rec_valid),
    .rec_ptr          (rec_ptr),
    .rec_count        (rec_count),
    .rec_top          (rec_top),
    .ex_valid         (ex_valid),
    .ex_pred_target   (ex_pred_target),
    .ex_actual_target (ex_actual_target),
    .ret_mispredict   (ret_mispredict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (rec_count <= 6'd32) else $fatal(1, "FAIL rec_count_legal obs=%0d max=32", rec_count);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
    cyc();
    if_valid = 1'b0;
  endtask

  // A harmless fetch exposes the current pointer/occupancy/top via ckpt_*.
  task automatic peek(input string tag, input logic [4:0] p, input logic [5:0] c,
                      input logic [31:0] t);
    fetch(32'h0, I_NOP);
    chk({tag, "_ptr"}, 32'(ckpt_ptr), 32'(p));
    chk({tag, "_cnt"}, 32'(ckpt_count), 32'(c));
    if (c != 0) chk({tag, "_top"}, ckpt_top, t);
    chk({tag, "_pv"}, 32'(pred_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0;
    rec_valid = 1'b0; rec_ptr = '0; rec_count = '0; rec_top = '0;
    ex_valid = 1'b0; ex_pred_target = '0; ex_actual_target = '0;
    do_reset();

    // Reset state
    chk("rst_pv",   32'(pred_valid), 32'd0);
    chk("rst_pt",   pred_target, 32'd0);
    chk("rst_cptr", 32'(ckpt_ptr), 32'd0);
    chk("rst_ccnt", 32'(ckpt_count), 32'd0);
    chk("rst_ctop", ckpt_top, 32'd0);
    chk("rst_mis",  32'(ret_mispredict), 32'd0);

    // Single call
    fetch(32'h100, I_CALL);
    chk("call1_pv",   32'(pred_valid), 32'd0);
    chk("call1_ccnt", 32'(ckpt_count), 32'd0);
    peek("call1_after", 5'd1, 6'd1, 32'h104);

    // Nested call/return
    fetch(32'h200, I_CALL);
    fetch(32'h300, I_RET);
    chk("ret1_pv", 32'(pred_valid), 32'd1);
    chk("ret1_pt", pred_target, 32'h204);
    fetch(32'h108, I_RET);
    chk("ret2_pv", 32'(pred_valid), 32'd1);
    chk("ret2_pt", pred_target, 32'h104);
    peek("nest_after", 5'd0, 6'd0, 32'h0);

    // Return on empty stack
    fetch(32'h500, I_RET);
    chk("empty_pv", 32'(pred_valid), 32'd0);
    chk("empty_pt", pred_target, 32'd0);
    peek("empty_after", 5'd0, 6'd0, 32'h0);

    // Overflow: 33 pushes then 33 returns
    for (int k = 0; k < 33; k++) fetch(32'h1000 + 32'(4 * k), I_CALL);
    peek("ovf_full", 5'd1, 6'd32, 32'h1084);
    for (int j = 0; j < 32; j++) begin
      fetch(32'h2000, I_RET);
      chk("ovf_ret_pv", 32'(pred_valid), 32'd1);
      chk("ovf_ret_pt", pred_target, 32'h1084 - 32'(4 * j));
    end
    fetch(32'h2000, I_RET);
    chk("ovf_ret33_pv", 32'(pred_valid), 32'd0);
    peek("ovf_drained", 5'd1, 6'd0, 32'h0);

    // Checkpoint and recovery
    do_reset();
    fetch(32'h100, I_CALL);
    fetch(32'h0, I_NOP);
    sv_ptr = ckpt_ptr; sv_count = ckpt_count; sv_top = ckpt_top;
    chk("ck_ptr", 32'(sv_ptr), 32'd1);
    chk("ck_cnt", 32'(sv_count), 32'd1);
    chk("ck_top", sv_top, 32'h104);
    fetch(32'h140, I_RET);
    chk("ck_pop_pt", pred_target, 32'h104);
    fetch(32'h300, I_CALL);
    rec_valid = 1'b1; rec_ptr = sv_ptr; rec_count = sv_count; rec_top = sv_top;
    fetch(32'h500, I_CALL);
    rec_valid = 1'b0;
    chk("rec_pv", 32'(pred_valid), 32'd0);
    fetch(32'h600, I_RET);
    chk("rec_ret_pv", 32'(pred_valid), 32'd1);
    chk("rec_ret_pt", pred_target, 32'h104);
    peek("rec_after", 5'd0, 6'd0, 32'h0);

    // Pop-then-push
    fetch(32'h100, I_CALL);
    fetch(32'h400, I_PP);
    chk("pp_pv", 32'(pred_valid), 32'd1);
    chk("pp_pt", pred_target, 32'h104);
    peek("pp_after", 5'd1, 6'd1, 32'h404);

    // Pop-then-push on empty behaves as push
    do_reset();
    fetch(32'h800, I_PP);
    chk("pp_empty_pv", 32'(pred_valid), 32'd0);
    peek("pp_empty_after", 5'd1, 6'd1, 32'h804);

    // Mispredict pulse
    ex_valid = 1'b1; ex_pred_target = 32'h104; ex_actual_target = 32'h108;
    cyc();
    ex_valid = 1'b0;
    chk("mis_pulse", 32'(ret_mispredict), 32'd1);
    cyc();
    chk("mis_clear", 32'(ret_mispredict), 32'd0);
    ex_valid = 1'b1; ex_actual_target = 32'h104;
    cyc();
    ex_valid = 1'b0;
    chk("mis_equal", 32'(ret_mispredict), 32'd0);

    // Reset overrides a flush in the same cycle
    reset = 1'b1; rec_valid = 1'b1; rec_ptr = 5'd7; rec_count = 6'd3; rec_top = 32'hABC;
    cyc();
    reset = 1'b0; rec_valid = 1'b0;
    chk("rstflush_ccnt", 32'(ckpt_count), 32'd0);
    peek("rstflush_after", 5'd0, 6'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
